// File: rtl/fpu_fclass_pipe.sv
// fpu_fclass_pipe: two-stage pipelined RISC-V FCLASS unit.
// Stage 1 holds the raw operand/format/tag and decodes the class flags;
// stage 2 holds the encoded one-hot mask and tag and drives the outputs.
// Both sides use a valid/ready handshake; flush_i kills everything in flight.
module fpu_fclass_pipe #(
  parameter int unsigned FLEN  = 64,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [FLEN-1:0]  in_operand_i,
  input  logic             in_fmt_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_mask_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam bit HAS_DOUBLE = (FLEN == 64);

  // One-hot FCLASS encoding; the if-chain order is the class priority.
  function automatic logic [9:0] f_classify(
    input logic sign,
    input logic box_fail,
    input logic exp_ones,
    input logic exp_zero,
    input logic man_zero,
    input logic man_msb
  );
    logic [9:0] m;
    if (box_fail)                  m = 10'h200;
    else if (exp_ones && man_zero) m = sign ? 10'h001 : 10'h080;
    else if (exp_zero && man_zero) m = sign ? 10'h008 : 10'h010;
    else if (exp_ones)             m = man_msb ? 10'h200 : 10'h100;
    else if (exp_zero)             m = sign ? 10'h004 : 10'h020;
    else                           m = sign ? 10'h002 : 10'h040;
    return m;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [FLEN-1:0]  s1_op_q;
  logic             s1_fmt_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  s2_mask_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s2_load;
  logic             s1_adv;
  logic             in_fire;

  logic [63:0]      op_w;
  logic             dbl_w;
  logic             sign_w, box_fail_w, exp_ones_w, exp_zero_w, man_zero_w, man_msb_w;
  logic [XLEN-1:0]  mask_w;

  // Handshake: stage 2 frees when empty or drained; stage 1 advances into it.
  always_comb begin
    s2_load    = !s2_valid_q || out_ready_i;
    s1_adv     = s1_valid_q && s2_load;
    in_ready_o = !s1_valid_q || s1_adv;
    in_fire    = in_valid_i && in_ready_o;

    s1_valid_d = s1_valid_q;
    if (flush_i)      s1_valid_d = 1'b0;
    else if (in_fire) s1_valid_d = 1'b1;
    else if (s1_adv)  s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (flush_i)      s2_valid_d = 1'b0;
    else if (s2_load) s2_valid_d = s1_valid_q;
  end

  // Stage 1 field decode. A 32-bit build zero-extends so both field
  // positions are always addressable; the format bit is forced to single.
  always_comb begin
    op_w       = 64'(s1_op_q);
    dbl_w      = HAS_DOUBLE && s1_fmt_q;
    sign_w     = dbl_w ? op_w[63]        : op_w[31];
    exp_ones_w = dbl_w ? (&op_w[62:52])  : (&op_w[30:23]);
    exp_zero_w = dbl_w ? ~(|op_w[62:52]) : ~(|op_w[30:23]);
    man_zero_w = dbl_w ? ~(|op_w[51:0])  : ~(|op_w[22:0]);
    man_msb_w  = dbl_w ? op_w[51]        : op_w[22];
    box_fail_w = HAS_DOUBLE && !s1_fmt_q && !(&op_w[63:32]);
    mask_w     = XLEN'(f_classify(sign_w, box_fail_w, exp_ones_w,
                                  exp_zero_w, man_zero_w, man_msb_w));
  end

  // Valid flags: the only state that must be cleared by reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 data capture on an accepted input; no reset needed.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      s1_op_q  <= in_operand_i;
      s1_fmt_q <= in_fmt_i;
      s1_tag_q <= in_tag_i;
    end
  end

  // Stage 2 output registers; cleared on reset so outputs read zero.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s2_mask_q <= '0;
      s2_tag_q  <= '0;
    end else if (s1_adv) begin
      s2_mask_q <= mask_w;
      s2_tag_q  <= s1_tag_q;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_mask_o  = s2_mask_q;
  assign out_tag_o   = s2_tag_q;

endmodule
